// File: rtl/dac_share_scheduler_if.sv
// Requester/DAC bundle for the shared-DAC scheduler: request valid/code in, one-hot ready out, DAC code and status out.
// Latency: n/a (wires only); the scheduler defines the timing of each signal.
// Backpressure: req_ready is the accept; a requester holds req_code stable while req_valid is high and req_ready low.
//
// Signals:
//   req_valid  [NUM_REQ]         per-requester request valid
//   req_code   [NUM_REQ*CODE_W]  packed codes, requester i at [i*CODE_W +: CODE_W]
//   req_ready  [NUM_REQ]         one-hot accept (combinational in the scheduler)
//   dac_d      [CODE_W]          registered code driving the DAC D input
//   dac_upd                      one-cycle pulse when dac_d takes a new code
//   busy                         high while the code is settling
//   last_grant [IDX_W]           index of the most recently accepted requester
interface dac_share_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int CODE_W  = 10
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic [NUM_REQ-1:0]        req_ready;
    logic [CODE_W-1:0]         dac_d;
    logic                      dac_upd;
    logic                      busy;
    logic [IDX_W-1:0]          last_grant;

    // Requester side.
    modport master (
        output req_valid, req_code,
        input  req_ready, dac_d, dac_upd, busy, last_grant
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_code,
        output req_ready, dac_d, dac_upd, busy, last_grant
    );
endinterface

// File: rtl/dac_share_scheduler.sv
// Shares one DAC between NUM_REQ requesters: round-robin pick, register the winning code, hold it for a settle window.
// Latency: accept is combinational in IDLE; the code appears on dac_d one cycle later, next accept SETTLE_CYCLES+1 cycles after.
// Backpressure: req_ready is all-zero while settling or in reset; waiting requesters hold valid/code, nothing is queued.
//
// Ports:
//   CLK      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      dac_share_scheduler_if.slave (must be instantiated with the same NUM_REQ and CODE_W)
module dac_share_scheduler #(
    parameter int                NUM_REQ       = 2,
    parameter int                CODE_W        = 10,
    parameter int                SETTLE_CYCLES = 4,
    parameter logic [CODE_W-1:0] RESET_CODE    = '0
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    dac_share_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] dac_q, dac_d;
    logic              upd_q, upd_d;
    logic [IDX_W-1:0]  last_q, last_d;

    // Round-robin search: start one past the last winner and wrap.
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    int                 cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = last_q;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && bus.req_valid[IDX_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Acceptance only in IDLE and never while reset is asserted, so req_ready
    // is forced low the instant reset_n falls.
    logic accept;
    assign accept = reset_n && (state_q == ST_IDLE) && grant_any;

    logic [CODE_W-1:0] win_code;
    always_comb begin
        win_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                win_code = bus.req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dac_d   = dac_q;
        upd_d   = 1'b0;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Code passes through untouched; an unchanged code still
                    // gets a full update pulse and settle window.
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_LOAD;
                    dac_d   = win_code;
                    upd_d   = 1'b1;
                    last_d  = grant_idx;
                end
            end
            ST_SETTLE: begin
                // Counter starts at SETTLE_CYCLES-1 so busy lasts exactly
                // SETTLE_CYCLES cycles.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dac_q   <= RESET_CODE;
            upd_q   <= 1'b0;
            last_q  <= LAST_IDX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dac_q   <= dac_d;
            upd_q   <= upd_d;
            last_q  <= last_d;
        end
    end

    assign bus.req_ready  = accept ? grant_oh : '0;
    assign bus.dac_d      = dac_q;
    assign bus.dac_upd    = upd_q;
    assign bus.busy       = (state_q == ST_SETTLE);
    assign bus.last_grant = last_q;

    a_ready_onehot: assert property (@(posedge CLK) disable iff (!reset_n)
        $onehot0(bus.req_ready));
    a_no_ready_when_busy: assert property (@(posedge CLK) disable iff (!reset_n)
        bus.busy |-> (bus.req_ready == '0));
    a_ready_needs_valid: assert property (@(posedge CLK) disable iff (!reset_n)
        ((bus.req_ready & ~bus.req_valid) == '0));
endmodule

// File: tb/tb_dac_share_scheduler.sv
module tb_dac_share_scheduler;
    localparam int NR = 2;
    localparam int CW = 10;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dac_share_scheduler_if #(.NUM_REQ(NR), .CODE_W(CW)) bus();

    dac_share_scheduler #(
        .NUM_REQ(NR), .CODE_W(CW), .SETTLE_CYCLES(SC), .RESET_CODE(10'h000)
    ) dut (
        .CLK(clk), .reset_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // m_left: settle cycles still to run; m_last: round-robin pointer.
    int               m_left    = 0;
    logic [CW-1:0]    m_dac     = '0;
    int               m_last    = NR - 1;
    logic             m_upd     = 1'b0;
    logic [NR-1:0]    m_granted = '0;

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        int p;
        logic [NR-1:0] r;
        r = '0;
        if (rst_n === 1'b1 && m_left == 0) begin
            p = rr_pick(m_last, bus.req_valid);
            if (p >= 0) r[p] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_left = 0; m_dac = '0; m_last = NR - 1; m_upd = 1'b0; m_granted = '0;
        end else begin
            m_granted = '0;
            m_upd = 1'b0;
            if (m_left > 0) begin
                m_left--;
            end else begin
                w = rr_pick(m_last, bus.req_valid);
                if (w >= 0) begin
                    m_dac = bus.req_code[w*CW +: CW];
                    m_last = w;
                    m_left = SC;
                    m_upd = 1'b1;
                    m_granted[w] = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        check("m_ready", bus.req_ready, exp_ready());
        check("m_dac_d", bus.dac_d, m_dac);
        check("m_upd", bus.dac_upd, m_upd);
        check("m_busy", bus.busy, (m_left > 0));
        check("m_last", bus.last_grant, m_last);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        repeat (n) step();
    endtask

    task automatic set_code(input int i, input logic [CW-1:0] c);
        bus.req_code[i*CW +: CW] = c;
    endtask

    logic [CW-1:0] seq_d [$];
    logic [31:0]   seq_g [$];

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_code  = '0;

        // 1: reset held with both valid
        bus.req_valid = 2'b11;
        set_code(0, 10'h011);
        set_code(1, 10'h022);
        repeat (3) begin
            @(negedge clk);
            check("rst_dac", bus.dac_d, 10'h000);
            check("rst_ready", bus.req_ready, 2'b00);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_upd", bus.dac_upd, 1'b0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", bus.req_ready, 2'b01);
        step();
        idle(6);

        // 2: single request timing
        bus.req_valid = 2'b01;
        set_code(0, 10'h3FF);
        @(negedge clk);
        check("single_ready_t", bus.req_ready, 2'b01);
        step();
        set_code(0, 10'h001);
        @(negedge clk);
        check("single_dac_t1", bus.dac_d, 10'h3FF);
        check("single_upd_t1", bus.dac_upd, 1'b1);
        check("single_busy_t1", bus.busy, 1'b1);
        for (int c = 2; c <= 4; c++) begin
            step();
            @(negedge clk);
            check("single_busy_hold", bus.busy, 1'b1);
            check("single_ready_hold", bus.req_ready, 2'b00);
        end
        step();
        @(negedge clk);
        check("single_busy_t5", bus.busy, 1'b0);
        check("single_ready_t5", bus.req_ready, 2'b01);
        step();
        @(negedge clk);
        check("single_dac_t6", bus.dac_d, 10'h001);
        idle(6);

        // 3: contention after a fresh reset (pointer at 1, req0 first)
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_code(0, 10'h155);
        set_code(1, 10'h2AA);
        bus.req_valid = 2'b11;
        repeat (20) begin
            @(negedge clk);
            if (bus.dac_upd === 1'b1) begin
                seq_d.push_back(bus.dac_d);
                seq_g.push_back(32'(bus.last_grant));
            end
            step();
        end
        bus.req_valid = '0;
        check("cont_pulses", seq_d.size(), 4);
        for (int i = 0; i < 4 && i < seq_d.size(); i++) begin
            check("cont_dac", seq_d[i], (i % 2 == 0) ? 10'h155 : 10'h2AA);
            check("cont_last", seq_g[i], i % 2);
        end
        idle(6);

        // 4: req1 granted, req0 arrives during settle and wins first IDLE
        bus.req_valid = 2'b10;
        set_code(1, 10'h100);
        step();
        bus.req_valid = 2'b01;
        set_code(0, 10'h080);
        repeat (4) step();
        @(negedge clk);
        check("wrap_ready", bus.req_ready, 2'b01);
        step();
        @(negedge clk);
        check("wrap_dac", bus.dac_d, 10'h080);
        check("wrap_last", bus.last_grant, 1'b0);
        idle(6);

        // 6: withdrawn request during settle
        bus.req_valid = 2'b10;
        set_code(1, 10'h0F0);
        step();
        bus.req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.req_valid = (i < 2) ? 2'b01 : 2'b00;
            set_code(0, 10'h222);
            @(negedge clk);
            check("wd_ready", bus.req_ready, 2'b00);
            check("wd_upd", bus.dac_upd, 1'b0);
            check("wd_dac", bus.dac_d, 10'h0F0);
        end
        idle(2);

        // 5: async reset mid-settle
        bus.req_valid = 2'b01;
        set_code(0, 10'h1AB);
        step();
        bus.req_valid = 2'b10;
        set_code(1, 10'h2CD);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dac", bus.dac_d, 10'h000);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ready", bus.req_ready, 2'b00);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_grant", bus.req_ready, 2'b10);
        step();
        @(negedge clk);
        check("arst_dac2", bus.dac_d, 10'h2CD);
        check("arst_upd2", bus.dac_upd, 1'b1);
        idle(6);

        // Randomized traffic obeying the hold-while-waiting rule
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i] || m_granted[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_code(i, CW'($urandom_range(0, (1 << CW) - 1)));
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
